serial_mac: RTL and testbench
=============================

# serial_mac

Parametrised bit-serial multiply-accumulate unit for the accelerator datapath. Multiplies a parallel sign-magnitude fixed-point neuron value by a serially delivered sign-magnitude weight and accumulates successive products into a wide two's-complement accumulator. Emits a saturated sign-magnitude result when the final term of a dot product completes. Sits between the weight-stream fetch and the activation stage, one instance per neuron lane.

## Interface
- DATA_W, 16, total operand/result width: 1 sign bit + INT_W + FRAC_W magnitude bits
- INT_W, 5, integer magnitude bits
- FRAC_W, 10, fraction bits; DATA_W = 1 + INT_W + FRAC_W is required
- ACC_GUARD, 8, extra accumulator headroom bits
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  a new term is offered
- in_ready  output  1  unit can accept a term; high exactly when in IDLE
- first  input  1  sampled at handshake; 1 = clear accumulator before adding this term
- last  input  1  sampled at handshake; 1 = emit result after this term
- neuron  input  DATA_W  sign-magnitude neuron; sampled at handshake, ignored afterwards
- weight_bit  input  1  serial weight: sign at handshake cycle, then DATA_W-1 magnitude bits MSB first
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out  output  DATA_W  sign-magnitude result
- sat  output  1  result was clipped; qualifies out

## Operation
- States: IDLE, MUL, ACC, DONE.
- IDLE: in_ready=1. On in_valid: latch neuron, first, last; latch weight_bit as weight sign; clear partial product; counter=0; go MUL.
- MUL: DATA_W-1 cycles; each edge partial <= (partial<<1) + (weight_bit ? neuron[DATA_W-2:0] : 0); counter++. After counter reaches DATA_W-2, go ACC. weight_bit is only sampled in IDLE-handshake and MUL cycles.
- Partial product width 2*(DATA_W-1). Scaled term = partial >> FRAC_W (magnitude truncation, toward zero). Term sign = neuron sign XOR weight sign.
- ACC: accumulator width ACC_W = 2*(DATA_W-1) - FRAC_W + ACC_GUARD + 1, two's complement. acc <= (first ? 0 : acc) ± term. If last go DONE, else IDLE.
- Accumulator wraps silently on overflow beyond ACC_W; no saturation inside the accumulator.
- DONE: out = sign-magnitude of acc; magnitude > 2^(DATA_W-1)-1 clips to 2^(DATA_W-1)-1 with sat=1. Zero result always +0 (never sign=1 with zero magnitude). out_valid=1; out, sat held stable until out_valid&out_ready, then go IDLE. Accumulator retained (next term normally has first=1).
- in_valid ignored outside IDLE; out_ready ignored outside DONE.

## Timing
- Reset (asserted at any time, including mid-term or in DONE): state IDLE, accumulator, partial, counter cleared; out=0, sat=0, out_valid=0, in_ready=1 while reset is low and after release.
- Handshake at cycle T (sign bit on weight_bit in T); magnitude bits in T+1..T+DATA_W-1.
- ACC at T+DATA_W; in_ready high again at T+DATA_W+1 (non-last term) — one term per DATA_W+1 cycles.
- Last term: out_valid first high at T+DATA_W+1; with out_ready held high, in_ready high at T+DATA_W+2.
- out/sat registered; change only on transition into DONE or on reset.

## Test plan
- Single term, default params: neuron 0x0800 (2.0), weight 0x0600 (1.5), first=last=1 -> out 0x0C00, sat=0, out_valid at T+17.
- Sign: neuron 0x8800 (-2.0), weight 0x0600 -> out 0x8C00; neuron 0x8800, weight 0x8600 -> 0x0C00.
- Accumulate 3 terms (1.0*1.0, 2.0*0.5, 0.25*4.0 i.e. 0x0400/0x0400, 0x0800/0x0200, 0x0100/0x1000), first on term 1, last on term 3 -> out 0x0C00; in_ready gaps exactly 17 cycles; no out_valid before term 3.
- Saturation: 0x5000 (20.0) * 0x1000 (4.0) -> out 0x7FFF, sat=1; negative: 0xD000 * 0x1000 -> 0xFFFF, sat=1. Cancellation 0x0400*0x0400 + 0x8400*0x0400 -> 0x0000, not 0x8000.
- Backpressure: out_ready low 5 cycles after out_valid -> out, sat stable, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 next cycle.
- Reset asserted at MUL counter=7 -> outputs 0, in_ready=1 immediately; next term with first=0, 0x0400*0x0400, last=1 -> out 0x0400 (accumulator was cleared).

Source files
------------

// File: rtl/serial_mac.sv
// Bit-serial sign-magnitude multiply-accumulate lane. The neuron is taken in parallel
// and the weight serially (sign first, then magnitude MSB first). Products are summed
// in a wrapping two's-complement accumulator, and a saturated result is emitted on the last term.
module serial_mac #(
  parameter int DATA_W    = 16,
  parameter int INT_W     = 5,
  parameter int FRAC_W    = 10,
  parameter int ACC_GUARD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              first,
  input  logic              last,
  input  logic [DATA_W-1:0] neuron,
  input  logic              weight_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              sat,
  output logic [1:0]        dbg_state
);

  localparam int MAG_W  = INT_W + FRAC_W;
  localparam int PROD_W = 2 * MAG_W;
  localparam int TERM_W = PROD_W - FRAC_W;
  localparam int ACC_W  = TERM_W + ACC_GUARD + 1;
  localparam int CNT_W  = $clog2(MAG_W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);
  localparam logic [ACC_W-1:0] MAG_MAX  = {{(ACC_W - MAG_W){1'b0}}, {MAG_W{1'b1}}};

  // Handshakes: a term is accepted on a rising edge with in_valid && in_ready;
  // a result is consumed on a rising edge with out_valid && out_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q;
  logic [PROD_W-1:0]   partial_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [MAG_W-1:0]    nmag_q;
  logic                nsign_q;
  logic                wsign_q;
  logic                first_q;
  logic                last_q;
  logic [DATA_W-1:0]   out_q;
  logic                sat_q;

  logic [PROD_W-1:0]   partial_d;
  logic [ACC_W-1:0]    term_ext;
  logic [ACC_W-1:0]    acc_base;
  logic [ACC_W-1:0]    acc_d;
  logic                acc_neg;
  logic [ACC_W-1:0]    acc_mag;
  logic [DATA_W-1:0]   out_d;
  logic                sat_d;

  always_comb begin
    partial_d = (partial_q << 1)
              + (weight_bit ? {{(PROD_W - MAG_W){1'b0}}, nmag_q} : '0);
    // Truncating the magnitude before applying the sign rounds toward zero.
    term_ext  = {{(ACC_W - TERM_W){1'b0}}, partial_q[PROD_W-1:FRAC_W]};
    acc_base  = first_q ? '0 : acc_q;
    acc_d     = (nsign_q ^ wsign_q) ? (acc_base - term_ext) : (acc_base + term_ext);
    acc_neg   = acc_d[ACC_W-1];
    acc_mag   = acc_neg ? (~acc_d + 1'b1) : acc_d;
    // A negative accumulator never has zero magnitude, so the sign bit cannot produce -0.
    if (acc_mag > MAG_MAX) begin
      out_d = {acc_neg, {MAG_W{1'b1}}};
      sat_d = 1'b1;
    end else begin
      out_d = {acc_neg, acc_mag[MAG_W-1:0]};
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      partial_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      nmag_q    <= '0;
      nsign_q   <= 1'b0;
      wsign_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      out_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            nmag_q    <= neuron[MAG_W-1:0];
            nsign_q   <= neuron[DATA_W-1];
            wsign_q   <= weight_bit;
            first_q   <= first;
            last_q    <= last;
            partial_q <= '0;
            cnt_q     <= '0;
            state_q   <= S_MUL;
          end
        end
        S_MUL: begin
          partial_q <= partial_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_q <= acc_d;
          if (last_q) begin
            out_q   <= out_d;
            sat_q   <= sat_d;
            state_q <= S_DONE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign sat       = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_mac.sv
// Bench for serial_mac: directed and random dot products are checked against an
// arithmetic model of the multiply-accumulate, with per-cycle output checking.
module tb_serial_mac;

  localparam int DATA_W    = 16;
  localparam int INT_W     = 5;
  localparam int FRAC_W    = 10;
  localparam int ACC_GUARD = 8;
  localparam int MAG_W     = DATA_W - 1;
  localparam int ACC_W     = 2 * MAG_W - FRAC_W + ACC_GUARD + 1;
  localparam longint MAG_MAX = (longint'(1) << MAG_W) - 1;
  localparam int LATENCY   = DATA_W + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              first = 1'b0;
  logic              last = 1'b0;
  logic              weight_bit = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] neuron = '0;
  logic              in_ready;
  logic              out_valid;
  logic              sat;
  logic [DATA_W-1:0] out;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] hold_v = '0;
  logic [DATA_W:0] last_model = '0;
  longint acc_m = 0;
  int ready_mode = 0;

  serial_mac #(
    .DATA_W(DATA_W), .INT_W(INT_W), .FRAC_W(FRAC_W), .ACC_GUARD(ACC_GUARD)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .first(first), .last(last), .neuron(neuron), .weight_bit(weight_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    longint r;
    r = v & ((longint'(1) << ACC_W) - 1);
    if (r >= (longint'(1) << (ACC_W - 1))) r = r - (longint'(1) << ACC_W);
    return r;
  endfunction

  function automatic logic [DATA_W:0] encode(input longint a);
    longint mag;
    logic [DATA_W:0] r;
    mag = (a < 0) ? -a : a;
    if (mag > MAG_MAX) r = {1'b1, (a < 0), MAG_W'(MAG_MAX)};
    else r = {1'b0, (a < 0), MAG_W'(mag)};
    return r;
  endfunction

  task automatic model_term(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] w,
                            input logic f, input logic l);
    longint mag;
    mag = (longint'(n[MAG_W-1:0]) * longint'(w[MAG_W-1:0])) >>> FRAC_W;
    if (n[DATA_W-1] ^ w[DATA_W-1]) mag = -mag;
    acc_m = wrap_acc((f ? 0 : acc_m) + mag);
    if (l) begin
      last_model = encode(acc_m);
      exp_q.push_back(last_model);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (!reset) begin
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out", 32'({sat, out}), 32'd0);
    end else begin
      check("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: out=%h sat=%b, no result expected", out, sat);
        end else begin
          e = exp_q[0];
          check("out", 32'(out), 32'(e[DATA_W-1:0]));
          check("sat", 32'(sat), 32'(e[DATA_W]));
          hold_v = e;
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_hold", 32'({sat, out}), 32'(hold_v));
      end
    end
  end

  task automatic send_term(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] w,
                           input logic f, input logic l, input int abort_k);
    int k;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
      return;
    end
    model_term(n, w, f, l);
    in_valid = 1'b1;
    first = f;
    last = l;
    neuron = n;
    weight_bit = w[DATA_W-1];
    @(posedge clk);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (abort_k == k) begin
        #2;
        reset = 1'b0;
        exp_q.delete();
        hold_v = '0;
        acc_m = 0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_outputs", 32'({out_valid, sat, out}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (in_ready || out_valid) break;
      if (k <= MAG_W) begin
        in_valid = 1'($urandom_range(0, 1));
        neuron = DATA_W'($urandom);
        first = 1'($urandom_range(0, 1));
        last = 1'($urandom_range(0, 1));
        weight_bit = w[MAG_W-k];
      end else begin
        in_valid = 1'b0;
        weight_bit = 1'($urandom_range(0, 1));
      end
    end
    check("term_latency", 32'(k), 32'(LATENCY));
    check("term_end_kind", 32'({out_valid, in_ready}), l ? 32'd2 : 32'd1);
    in_valid = 1'b0;
    weight_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int waited;
    ready_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] w;
    int len;
    #3;
    check("por_in_ready", 32'(in_ready), 32'd1);
    check("por_outputs", 32'({out_valid, sat, out}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    send_term(16'h0800, 16'h0600, 1'b1, 1'b1, 0);
    check("pin_2x1p5", 32'(last_model), 32'h00C00);
    send_term(16'h8800, 16'h0600, 1'b1, 1'b1, 0);
    check("pin_neg2x1p5", 32'(last_model), 32'h08C00);
    send_term(16'h8800, 16'h8600, 1'b1, 1'b1, 0);
    check("pin_neg2xneg1p5", 32'(last_model), 32'h00C00);

    send_term(16'h0400, 16'h0400, 1'b1, 1'b0, 0);
    send_term(16'h0800, 16'h0200, 1'b0, 1'b0, 0);
    send_term(16'h0100, 16'h1000, 1'b0, 1'b1, 0);
    check("pin_three_terms", 32'(last_model), 32'h00C00);

    send_term(16'h5000, 16'h1000, 1'b1, 1'b1, 0);
    check("pin_sat_pos", 32'(last_model), 32'h17FFF);
    send_term(16'hD000, 16'h1000, 1'b1, 1'b1, 0);
    check("pin_sat_neg", 32'(last_model), 32'h1FFFF);
    send_term(16'h0400, 16'h0400, 1'b1, 1'b0, 0);
    send_term(16'h8400, 16'h0400, 1'b0, 1'b1, 0);
    check("pin_cancel", 32'(last_model), 32'h00000);

    ready_mode = 2;
    send_term(16'h0C00, 16'h0400, 1'b1, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'({out_valid, in_ready}), 32'd2);
      in_valid = 1'($urandom_range(0, 1));
      neuron = DATA_W'($urandom);
      first = 1'($urandom_range(0, 1));
      last = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release", 32'({out_valid, in_ready}), 32'd1);

    send_term(16'h0400, 16'h0400, 1'b1, 1'b0, 0);
    send_term(16'h0800, 16'h0400, 1'b0, 1'b0, 8);
    send_term(16'h0400, 16'h0400, 1'b0, 1'b1, 0);
    check("pin_after_reset", 32'(last_model), 32'h00400);

    for (int i = 0; i < 260; i++) begin
      send_term(16'h7FFF, 16'h7FFF, 1'(i == 0), 1'(i == 259), 0);
    end
    check("pin_acc_wrap", 32'(last_model), 32'h1FFFF);

    for (int d = 0; d < 30; d++) begin
      ready_mode = $urandom_range(0, 1);
      len = $urandom_range(1, 4);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 1) == 1) begin
          n = DATA_W'($urandom);
          w = DATA_W'($urandom);
        end else begin
          n = {1'($urandom_range(0, 1)), MAG_W'($urandom_range(0, 16'h0FFF))};
          w = {1'($urandom_range(0, 1)), MAG_W'($urandom_range(0, 16'h0FFF))};
        end
        send_term(n, w, (t == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0),
                  1'(t == len - 1), 0);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
